// File: rtl/rv_bus_pkg.sv
// Shared types for the core-to-memory bus arbiter.
package rv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_DM
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int unsigned WSTRB_W = 4;

endpackage

// File: rtl/arb_starve_guard.sv
// Data-priority decision with a back-to-back DM grant limit so fetch cannot starve.
module arb_starve_guard #(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_if_req,
  input  logic i_dm_req,
  input  logic i_dm_granted,
  input  logic i_if_granted,
  output logic o_pick_dm
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] r_streak;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (i_dm_granted) begin
      if (!i_if_req)
        r_streak <= '0;
      else if (r_streak != MAX_S)
        r_streak <= r_streak + STREAK_W'(1);
    end else if (i_if_granted) begin
      r_streak <= '0;
    end
  end

  always_comb begin
    o_pick_dm = i_dm_req & (~i_if_req | (r_streak < MAX_S));
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and data ports, one transaction in flight.
module unified_mem_arbiter
  import rv_bus_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [XLEN-1:0]    if_addr,
  input  logic               if_flush,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [XLEN-1:0]    if_rdata,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [XLEN-1:0]    dm_addr,
  input  logic [XLEN-1:0]    dm_wdata,
  input  logic [WSTRB_W-1:0] dm_wstrb,
  output logic               dm_gnt,
  output logic               dm_rvalid,
  output logic [XLEN-1:0]    dm_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               spurious_rsp
);

  arb_state_t r_state, w_state_next;
  logic       r_lock, r_drop, r_wr;
  owner_t     r_lock_owner, w_owner;
  logic       w_pick_dm, w_req, w_accept, w_resp;

  arb_starve_guard #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_guard (
    .clk          (clk),
    .reset        (reset),
    .i_if_req     (if_req),
    .i_dm_req     (dm_req),
    .i_dm_granted (dm_gnt),
    .i_if_granted (if_gnt),
    .o_pick_dm    (w_pick_dm)
  );

  // A stalled request keeps its owner until memory accepts it.
  always_comb begin
    w_owner  = r_lock ? r_lock_owner : (w_pick_dm ? OWN_DM : OWN_IF);
    w_req    = ~reset & (r_state == IDLE) & ((w_owner == OWN_DM) ? dm_req : if_req);
    w_accept = w_req & mem_gnt;
    w_resp   = ~reset & mem_rvalid;
  end

  always_comb begin
    mem_req   = w_req;
    if_gnt    = w_accept & (w_owner == OWN_IF);
    dm_gnt    = w_accept & (w_owner == OWN_DM);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_req) begin
      if (w_owner == OWN_DM) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_wstrb = dm_wstrb;
      end else begin
        mem_addr  = if_addr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = (w_owner == OWN_DM) ? WAIT_DM : WAIT_IF;
      WAIT_IF,
      WAIT_DM: if (mem_rvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if_rvalid    = w_resp & (r_state == WAIT_IF) & ~r_drop & ~if_flush;
    dm_rvalid    = w_resp & (r_state == WAIT_DM);
    spurious_rsp = w_resp & (r_state == IDLE);
    if_rdata     = if_rvalid ? mem_rdata : '0;
    dm_rdata     = (dm_rvalid & ~r_wr) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lock       <= 1'b0;
      r_lock_owner <= OWN_IF;
      r_drop       <= 1'b0;
      r_wr         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_lock <= 1'b0;
        r_wr   <= (w_owner == OWN_DM) & dm_we;
      end else if (w_req) begin
        r_lock       <= 1'b1;
        r_lock_owner <= w_owner;
      end
      if (r_state == WAIT_IF)
        r_drop <= mem_rvalid ? 1'b0 : (r_drop | if_flush);
      else
        r_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scenarios followed by random traffic, checked against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb, mem_wstrb;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, spurious_rsp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Model: outstanding transaction (0 none, 1 fetch, 2 data), pending stalled owner, DM run length.
  int m_out = 0;
  bit m_out_wr = 0;
  bit m_lock = 0;
  bit m_lock_dm = 0;
  int m_streak = 0;
  bit m_drop = 0;
  bit e_sel_dm, e_req, e_acc;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.XLEN(32), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .spurious_rsp(spurious_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc_check();
    bit e_irv, e_drv;
    #2;
    e_sel_dm = m_lock ? m_lock_dm : (dm_req && (!if_req || m_streak < MAXS));
    e_req    = !reset && m_out == 0 && (e_sel_dm ? dm_req : if_req);
    e_acc    = e_req && mem_gnt;
    e_irv    = !reset && mem_rvalid && m_out == 1 && !m_drop && !if_flush;
    e_drv    = !reset && mem_rvalid && m_out == 2;
    chk("mem_req",   32'(mem_req),   32'(e_req));
    chk("if_gnt",    32'(if_gnt),    32'(e_acc && !e_sel_dm));
    chk("dm_gnt",    32'(dm_gnt),    32'(e_acc && e_sel_dm));
    chk("mem_we",    32'(mem_we),    32'(e_req && e_sel_dm && dm_we));
    chk("mem_addr",  mem_addr,  !e_req ? 32'h0 : (e_sel_dm ? dm_addr : if_addr));
    chk("mem_wdata", mem_wdata, (e_req && e_sel_dm) ? dm_wdata : 32'h0);
    chk("mem_wstrb", 32'(mem_wstrb), (e_req && e_sel_dm) ? 32'(dm_wstrb) : 32'h0);
    chk("if_rvalid", 32'(if_rvalid), 32'(e_irv));
    chk("if_rdata",  if_rdata,  e_irv ? mem_rdata : 32'h0);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_drv));
    chk("dm_rdata",  dm_rdata,  (e_drv && !m_out_wr) ? mem_rdata : 32'h0);
    chk("spurious",  32'(spurious_rsp), 32'(!reset && mem_rvalid && m_out == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_out = 0; m_out_wr = 0; m_lock = 0; m_streak = 0; m_drop = 0;
    end else if (m_out == 0) begin
      if (e_acc) begin
        m_out    = e_sel_dm ? 2 : 1;
        m_out_wr = e_sel_dm && dm_we;
        m_lock   = 0;
        if (e_sel_dm) m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        else          m_streak = 0;
      end else if (e_req) begin
        m_lock    = 1;
        m_lock_dm = e_sel_dm;
      end
    end else begin
      if (mem_rvalid) begin
        m_out  = 0;
        m_drop = 0;
      end else if (m_out == 1 && if_flush) begin
        m_drop = 1;
      end
    end
    #1;
  endtask

  initial begin
    bit if_pend, dm_pend;
    int cnt;
    reset = 1; if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int i = 0; i < 2; i++) begin cyc_check(); tick(); end

    // 1: reset in the middle of a data read, then a late response
    reset = 0; dm_req = 1; dm_addr = 32'h40; mem_gnt = 1;
    cyc_check(); chk("t1_dm_gnt", 32'(dm_gnt), 32'd1); tick();
    dm_req = 0; mem_gnt = 0; reset = 1; if_addr = 32'h1234; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    for (int i = 0; i < 3; i++) begin
      cyc_check(); chk("t1_rst_dm_rvalid", 32'(dm_rvalid), 32'd0); tick();
    end
    reset = 0;
    cyc_check();
    chk("t1_spurious", 32'(spurious_rsp), 32'd1);
    chk("t1_no_route", 32'(dm_rvalid), 32'd0);
    tick();
    mem_rvalid = 0;

    // 2: single fetch with two-cycle latency
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    cyc_check(); chk("t2_if_gnt", 32'(if_gnt), 32'd1); tick();
    if_req = 0;
    cyc_check(); chk("t2_req_c1", 32'(mem_req), 32'd0); tick();
    mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    cyc_check();
    chk("t2_rvalid", 32'(if_rvalid), 32'd1);
    chk("t2_rdata", if_rdata, 32'h0050_0093);
    chk("t2_req_c2", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 0;

    // 3: both ports saturating a zero-wait memory
    if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h3000; mem_gnt = 1;
    for (int k = 0; k < 10; k++) begin
      mem_rvalid = 0;
      cyc_check();
      chk("t3_order_dm", 32'(dm_gnt), 32'((k % 5) != 4));
      chk("t3_order_if", 32'(if_gnt), 32'((k % 5) == 4));
      tick();
      mem_rvalid = 1; mem_rdata = 32'(k);
      cyc_check(); tick();
    end
    mem_rvalid = 0; if_req = 0; dm_req = 0;

    // 4: stalled fetch keeps ownership when data arrives
    if_req = 1; if_addr = 32'h300; mem_gnt = 0;
    cyc_check(); chk("t4_addr_c0", mem_addr, 32'h300); tick();
    dm_req = 1; dm_addr = 32'h400;
    for (int i = 0; i < 2; i++) begin
      cyc_check(); chk("t4_addr_lock", mem_addr, 32'h300); chk("t4_no_steal", 32'(dm_gnt), 32'd0); tick();
    end
    mem_gnt = 1;
    cyc_check(); chk("t4_if_first", 32'(if_gnt), 32'd1); chk("t4_dm_wait", 32'(dm_gnt), 32'd0); tick();
    if_req = 0; mem_rvalid = 1;
    cyc_check(); tick();
    mem_rvalid = 0;
    cyc_check(); chk("t4_dm_next", 32'(dm_gnt), 32'd1); chk("t4_dm_addr", mem_addr, 32'h400); tick();
    dm_req = 0; mem_rvalid = 1;
    cyc_check(); tick();
    mem_rvalid = 0;

    // 5: flush while waiting, then flush on the response cycle
    if_req = 1; if_addr = 32'h500;
    cyc_check(); tick();
    if_req = 0; if_flush = 1;
    cyc_check(); tick();
    if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    cyc_check(); chk("t5_drop", 32'(if_rvalid), 32'd0); tick();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h504;
    cyc_check(); chk("t5_idle_again", 32'(mem_req), 32'd1); tick();
    if_req = 0;
    cyc_check(); tick();
    mem_rvalid = 1; if_flush = 1;
    cyc_check(); chk("t5_same_cycle", 32'(if_rvalid), 32'd0); tick();
    mem_rvalid = 0; if_flush = 0;

    // 6: byte-masked data write
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
    cyc_check();
    chk("t6_we", 32'(mem_we), 32'd1);
    chk("t6_wstrb", 32'(mem_wstrb), 32'h3);
    chk("t6_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    dm_req = 0; dm_we = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    cyc_check();
    chk("t6_ack", 32'(dm_rvalid), 32'd1);
    chk("t6_rdata0", dm_rdata, 32'h0);
    tick();
    mem_rvalid = 0;

    // Random traffic: requests held until granted, random latency, flushes, stray responses, resets
    if_pend = 0; dm_pend = 0; cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom;
        dm_wdata = $urandom; dm_wstrb = 4'($urandom_range(0, 15));
      end
      if_req = if_pend; dm_req = dm_pend;
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      if_flush = ($urandom_range(0, 7) == 0);
      if (m_out != 0) begin
        if (cnt == 0) mem_rvalid = 1;
        else begin mem_rvalid = 0; cnt--; end
      end else begin
        mem_rvalid = ($urandom_range(0, 19) == 0);
      end
      cyc_check();
      if (e_acc) begin
        if (e_sel_dm) dm_pend = 0; else if_pend = 0;
        cnt = $urandom_range(0, 2);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
